pipe_seg_adder: RTL and testbench

PIPE_SEG_ADDER -- requirements
Module: pipe_seg_adder

---
 rtl/pipe_seg_adder.sv | 117 +++++++++++
 tb/tb_pipe_seg_adder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_seg_adder.sv
// rtl/pipe_seg_adder.sv - segmented carry-pipelined adder/subtractor with valid/ready flow control
// Optional build macro: PIPE_SEG_ADDER_APPROX_EN (approximate lowest segment).
module pipe_seg_adder #(
   parameter int WIDTH     = 17,
   parameter int SEG_WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

   logic             advance;
   logic [WIDTH-1:0] bx;
   logic             c0;
   logic             ovf_q;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign bx       = in_sub ? ~in_b : in_b;
   assign c0       = in_sub | in_cin;

   // Stage k owns bits [LO +: SW]; it keeps the finished low sum bits and the
   // not-yet-added upper operand bits, so each carry only ever comes from a flop.
   for (genvar k = 0; k < NSEG; k++) begin : g_st
      localparam int LO = k * SEG_WIDTH;
      localparam int SW = (k == NSEG - 1) ? (WIDTH - LO) : SEG_WIDTH;
      localparam int HI = LO + SW;

      logic [WIDTH-LO-1:0] a_in;
      logic [WIDTH-LO-1:0] b_in;
      logic                c_in;
      logic                v_in;
      logic [SW:0]         seg;
      logic [HI-1:0]       s_d;
      logic [HI-1:0]       s_q;
      logic                c_q;
      logic                v_q;

      if (k == 0) begin : g_src
         assign a_in = in_a;
         assign b_in = bx;
         assign c_in = c0;
         assign v_in = in_valid;
         assign s_d  = seg[SW-1:0];
      end else begin : g_src
         assign a_in = g_st[k-1].g_up.ua_q;
         assign b_in = g_st[k-1].g_up.ub_q;
         assign c_in = g_st[k-1].c_q;
         assign v_in = g_st[k-1].v_q;
         assign s_d  = {seg[SW-1:0], g_st[k-1].s_q};
      end

`ifdef PIPE_SEG_ADDER_APPROX_EN
      if (k == 0) begin : g_add
         assign seg = {a_in[SW-1], {SW{a_in[SW-1]}}};
      end else begin : g_add
         assign seg = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};
      end
`else
      assign seg = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};
`endif

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (advance) begin
            v_q <= v_in;
            c_q <= seg[SW];
            s_q <= s_d;
         end
      end

      if (k < NSEG - 1) begin : g_up
         logic [WIDTH-HI-1:0] ua_q;
         logic [WIDTH-HI-1:0] ub_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ua_q <= '0;
               ub_q <= '0;
            end else if (advance) begin
               ua_q <= a_in[WIDTH-LO-1:SW];
               ub_q <= b_in[WIDTH-LO-1:SW];
            end
         end
      end else begin : g_last
         // Top stage still sees the operand sign bits, so overflow is resolved here.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= (a_in[SW-1] == b_in[SW-1]) && (seg[SW-1] != a_in[SW-1]);
            end
         end
      end
   end

   assign out_valid = g_st[NSEG-1].v_q;
   assign out_sum   = g_st[NSEG-1].s_q;
   assign out_cout  = g_st[NSEG-1].c_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipe_seg_adder.sv
// tb/tb_pipe_seg_adder.sv - self-checking bench for pipe_seg_adder (WIDTH=17, SEG_WIDTH=4)
// Honours PIPE_SEG_ADDER_APPROX_EN in its reference model.
module tb_pipe_seg_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] in_a;
   logic [16:0] in_b;
   logic        in_cin;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] out_sum;
   logic        out_cout;
   logic        out_ovf;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb_q[$];
   logic        hold = 1'b0;
   logic [31:0] held = '0;
   logic        obs_v = 1'b0;
   logic [31:0] obs_r = '0;

   pipe_seg_adder #(.WIDTH(17), .SEG_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {sum, cout, ovf} from plain integer arithmetic.
   function automatic logic [31:0] ref_add(input logic [16:0] a, input logic [16:0] b,
                                           input logic ci, input logic sb);
      logic [31:0] bp, tot, sum, cout, ovf;
      bp = sb ? {15'd0, ~b} : {15'd0, b};
`ifdef PIPE_SEG_ADDER_APPROX_EN
      tot  = (32'(a) >> 4) + (bp >> 4) + {31'd0, a[3]};
      sum  = ((tot & 32'h1FFF) << 4) | (a[3] ? 32'hF : 32'h0);
      cout = (tot >> 13) & 32'h1;
`else
      tot  = 32'(a) + bp + {31'd0, sb ? 1'b1 : ci};
      sum  = tot & 32'h1FFFF;
      cout = (tot >> 17) & 32'h1;
`endif
      ovf = ((a[16] == bp[16]) && (sum[16] != a[16])) ? 32'h1 : 32'h0;
      return (sum << 2) | (cout << 1) | ovf;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, sample/score before the rising edge.
   task automatic cyc(input logic iv, input logic [16:0] a, input logic [16:0] b,
                      input logic ci, input logic sb, input logic ordy,
                      output logic acc, output logic ir);
      logic [31:0] e;
      in_valid = iv; in_a = a; in_b = b; in_cin = ci; in_sub = sb; out_ready = ordy;
      #1;
      ir    = in_ready;
      acc   = iv && in_ready;
      obs_v = out_valid;
      obs_r = {13'd0, out_sum, out_cout, out_ovf};
      if (hold) begin
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_hold", obs_r, held);
      end
      if (out_valid && ordy) begin
         if (sb_q.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
         else begin
            e = sb_q.pop_front();
            chk("result", obs_r, e);
         end
      end
      if (acc) sb_q.push_back(ref_add(a, b, ci, sb));
      hold = out_valid && !ordy;
      held = obs_r;
      @(negedge clk);
   endtask

   task automatic lat_check(input string tag, input logic [16:0] a, input logic [16:0] b,
                            input logic ci, input logic sb, input logic [31:0] exp);
      logic acc, ir;
      int lat;
      logic [31:0] got;
      lat = 0;
      got = '0;
      cyc(1'b1, a, b, ci, sb, 1'b1, acc, ir);
      chk({tag, "_accept"}, {31'd0, acc}, 32'd1);
      for (int n = 1; n <= 12; n++) begin
         cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir);
         if (obs_v && lat == 0) begin
            lat = n;
            got = obs_r;
         end
      end
      chk({tag, "_latency"}, 32'(lat), 32'd5);
      chk(tag, got, exp);
   endtask

   logic        acc, ir;
   logic [16:0] ra, rb;
   logic        rc, rs;
   int          sent;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_sum", {15'd0, out_sum}, 32'd0);
      chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
      chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

`ifdef PIPE_SEG_ADDER_APPROX_EN
      lat_check("v035", 17'h1FFFF, 17'h00001, 1'b0, 1'b0, {13'd0, 17'h0000F, 1'b1, 1'b0});
      lat_check("v036", 17'h00005, 17'h00007, 1'b0, 1'b1, {13'd0, 17'h1FFF0, 1'b0, 1'b0});
      lat_check("v037", 17'h0FFFF, 17'h00001, 1'b0, 1'b0, {13'd0, 17'h1000F, 1'b0, 1'b1});
      lat_check("v040", 17'h0000F, 17'h00001, 1'b0, 1'b0, {13'd0, 17'h0001F, 1'b0, 1'b0});
`else
      lat_check("v035", 17'h1FFFF, 17'h00001, 1'b0, 1'b0, {13'd0, 17'h00000, 1'b1, 1'b0});
      lat_check("v036", 17'h00005, 17'h00007, 1'b0, 1'b1, {13'd0, 17'h1FFFE, 1'b0, 1'b0});
      lat_check("v037", 17'h0FFFF, 17'h00001, 1'b0, 1'b0, {13'd0, 17'h10000, 1'b0, 1'b1});
      lat_check("v040", 17'h0000F, 17'h00001, 1'b0, 1'b0, {13'd0, 17'h00010, 1'b0, 1'b0});
`endif

      // Eight back-to-back inputs; consumer stalls for the 3 cycles after the first result.
      sent = 0;
      ra = 17'($urandom); rb = 17'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      for (int n = 0; n < 20; n++) begin
         cyc(sent < 8, ra, rb, rc, rs, !(n >= 6 && n <= 8), acc, ir);
         chk("stall_in_ready", {31'd0, ir}, (n >= 6 && n <= 8) ? 32'd0 : 32'd1);
         if (acc) begin
            sent++;
            ra = 17'($urandom); rb = 17'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         end
      end
      chk("burst_sent", 32'(sent), 32'd8);
      chk("burst_drained", 32'(sb_q.size()), 32'd0);

      // Asynchronous reset with the pipeline full and the consumer stalled.
      for (int n = 0; n < 8; n++)
         cyc(1'b1, 17'($urandom), 17'($urandom), 1'($urandom), 1'($urandom), 1'b0, acc, ir);
      chk("prefill_valid", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_out_sum", {15'd0, out_sum}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      sb_q.delete();
      hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 10; n++) begin
         cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir);
         chk("post_rst_no_stale", {31'd0, obs_v}, 32'd0);
         chk("post_rst_in_ready", {31'd0, ir}, 32'd1);
      end

      // Random traffic against the scoreboard.
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 3) != 0, 17'($urandom), 17'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 9) < 7, acc, ir);
         chk("rand_in_ready", {31'd0, ir}, {31'd0, !obs_v || out_ready});
      end
      for (int n = 0; n < 12; n++)
         cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, ir);
      chk("rand_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
